force_coalescer: RTL and testbench
==================================

# force_coalescer

Parametrised multi-lane accumulator that merges consecutive force/velocity contributions carrying the same particle ID into one record per particle. It sits between the pairwise force pipelines and the position/velocity update stage. Each lane owns one in-progress accumulator and emits a summed record when the ID changes or on an explicit flush. Valid/ready handshakes on every lane allow downstream back-pressure.

## Interface
- NUM_LANES, 2, independent accumulation lanes (lane 0 = reference, lane 1 = neighbor in the default build)
- ID_W, 16, particle ID width
- COMP_W, 32, width of one signed vector component
- NUM_COMP, 3, components per record (x, y, z)
- CNT_W, 8, contribution-counter width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_valid  in  NUM_LANES  per-lane input record valid
- in_id  in  NUM_LANES*ID_W  per-lane particle ID, lane l at [l*ID_W +: ID_W]
- in_data  in  NUM_LANES*NUM_COMP*COMP_W  per-lane components, component c at the lowest offset first
- in_ready  out  1  shared; input accepted on lane l when in_valid[l] && in_ready
- flush  in  1  level request: drain all accumulators; hold until flush_ack
- flush_ack  out  1  one-cycle pulse once all lanes are EMPTY under flush
- out_valid  out  NUM_LANES  per-lane output record valid
- out_ready  in  NUM_LANES  per-lane downstream ready
- out_id  out  NUM_LANES*ID_W  emitted ID
- out_data  out  NUM_LANES*NUM_COMP*COMP_W  emitted sums
- out_cnt  out  NUM_LANES*CNT_W  number of contributions merged into the emitted record
- overflow  out  NUM_LANES  sticky; a component add overflowed on that lane since reset

## Operation
- Per-lane states: EMPTY, ACCUM. Each lane has an accumulator (id, data, cnt) and a single-entry output register.
- A lane slot is free when !out_valid[l] || out_ready[l]. in_ready = !flush && all lane slots free. This is combinational from out_ready and flush.
- Accepted input, EMPTY: load id and data, cnt=1, go to ACCUM. Nothing is emitted.
- Accepted input, ACCUM, same id: add the components element-wise into the accumulator and increment cnt, saturating at 2^CNT_W-1.
- Accepted input, ACCUM, different id: move the accumulator to the output register and set out_valid. Load the new record with cnt=1 and stay in ACCUM.
- Lanes with in_valid low keep their state.
- Component arithmetic is two's-complement signed, COMP_W bits. Default behaviour wraps modulo 2^COMP_W. Signed overflow sets overflow[l] in either mode.
- Flush: while flush is high, inputs are stalled because in_ready is 0.
  - Each ACCUM lane whose slot is free emits its accumulator and goes to EMPTY.
  - Lanes whose slot is not free wait.
  - When flush is high and every lane is EMPTY, flush_ack pulses for one cycle.
  - flush held after the ack produces no further ack until flush is deasserted for at least one cycle.
- An output record clears out_valid on out_valid && out_ready unless the same cycle loads a new record into it.
- Reset mid-operation discards accumulators and pending outputs.

## Timing
- Reset values:
  - out_valid=0, flush_ack=0, overflow=0, in_ready follows the rule above (1 after reset with flush low).
  - out_id/out_data/out_cnt = 0.
  - All lanes EMPTY.
- Emission latency: a record is displaced by a mismatching input accepted at cycle t, or flushed at t. out_valid rises at t+1.
- Single-record case: flush rises at t with a free slot. out_valid at t+1, flush_ack at t+1 (lanes EMPTY as of t+1 edge).
- Throughput: one input per lane per cycle when out_ready stays high.
- Output data is stable while out_valid && !out_ready.
- Simultaneous events:
  - Emit and downstream consume on one lane in the same cycle: the output register is replaced, and out_valid stays 1.
  - Lanes never interact except through the shared in_ready and flush_ack.

## Configuration
- FORCE_COALESCER_SAT_EN defined: component adds saturate to [-2^(COMP_W-1), 2^(COMP_W-1)-1], and overflow is still flagged.
- Undefined: adds wrap.
- Counter saturation is unconditional.

## Test plan
- Lane 0 gets ids 5,5,5 with data (1,2,3),(10,20,30),(-1,-2,-3), then id 7 (4,4,4) -> one output: id 5, (10,20,30), cnt 3. Lane 0 holds id 7.
- Then flush -> output id 7, (4,4,4), cnt 1. flush_ack one cycle later than out_valid rise, or same cycle if the slot is free.
- out_ready[1]=0 with a pending output, and lane 1 receives a mismatching id -> in_ready=0. No input is lost, and lane 0 is not accepted either. Release out_ready -> records appear in order.
- Lane 0 receives id 3 with x=0x7FFFFFFF twice:
  - SAT_EN: x=0x7FFFFFFF, overflow[0]=1.
  - Otherwise: x=0xFFFFFFFE, overflow[0]=1.
- 300 contributions to one id -> out_cnt=255.
- Assert reset while both lanes are in ACCUM with outputs pending -> out_valid=0, flush_ack=0, and a subsequent flush acks at t+1 with no outputs.

Source files
------------

// File: rtl/force_coalescer_if.sv
// -----------------------------------------------------------------------------
// force_coalescer_if
//
// Bundles the per-lane input stream, the per-lane output stream, the flush
// request/acknowledge pair and the status flags of force_coalescer.
//
// Handshake: a record moves across a lane boundary on a rising clk edge where
// valid and ready are both high. A producer raising valid keeps it and its
// payload unchanged until that edge. in_ready is shared by all lanes.
//
// Signals (lane l occupies slice l of each vector):
//   in_valid   [NUM_LANES]               input record valid
//   in_id      [NUM_LANES*ID_W]          input particle ID
//   in_data    [NUM_LANES*NUM_COMP*COMP_W] input components, x lowest
//   in_ready                             shared input ready
//   flush                                level request to drain accumulators
//   flush_ack                            one-cycle drain-complete pulse
//   out_valid  [NUM_LANES]               output record valid
//   out_ready  [NUM_LANES]               downstream ready
//   out_id / out_data / out_cnt          emitted record
//   overflow   [NUM_LANES]               sticky component-add overflow
//   lane_state [NUM_LANES]               debug view: 1 = lane is accumulating
//
// Modports: slave = coalescer side, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface force_coalescer_if #(
   parameter int NUM_LANES = 2,
   parameter int ID_W      = 16,
   parameter int COMP_W    = 32,
   parameter int NUM_COMP  = 3,
   parameter int CNT_W     = 8
);
   logic [NUM_LANES-1:0]                 in_valid;
   logic [NUM_LANES*ID_W-1:0]            in_id;
   logic [NUM_LANES*NUM_COMP*COMP_W-1:0] in_data;
   logic                                 in_ready;
   logic                                 flush;
   logic                                 flush_ack;
   logic [NUM_LANES-1:0]                 out_valid;
   logic [NUM_LANES-1:0]                 out_ready;
   logic [NUM_LANES*ID_W-1:0]            out_id;
   logic [NUM_LANES*NUM_COMP*COMP_W-1:0] out_data;
   logic [NUM_LANES*CNT_W-1:0]           out_cnt;
   logic [NUM_LANES-1:0]                 overflow;
   logic [NUM_LANES-1:0]                 lane_state;

   modport slave (
      input  in_valid, in_id, in_data, flush, out_ready,
      output in_ready, flush_ack, out_valid, out_id, out_data, out_cnt,
             overflow, lane_state
   );

   modport master (
      output in_valid, in_id, in_data, flush, out_ready,
      input  in_ready, flush_ack, out_valid, out_id, out_data, out_cnt,
             overflow, lane_state
   );
endinterface

// File: rtl/force_coalescer.sv
// -----------------------------------------------------------------------------
// force_coalescer
//
// Multi-lane accumulator merging consecutive contributions with the same
// particle ID into one record. Each lane keeps one in-progress accumulator
// and a single-entry output register. A record is emitted when a different
// ID arrives on the lane, or when a flush drains the lane.
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-high
//   bus    force_coalescer_if.slave (input stream, output stream, flush,
//          flush_ack, overflow, lane_state debug view)
//
// Build option:
//   FORCE_COALESCER_SAT_EN  defined   -> component adds saturate
//                           undefined -> component adds wrap
//   Signed overflow sets the sticky overflow flag in both builds; the
//   contribution counter always saturates.
// -----------------------------------------------------------------------------
module force_coalescer #(
   parameter int NUM_LANES = 2,
   parameter int ID_W      = 16,
   parameter int COMP_W    = 32,
   parameter int NUM_COMP  = 3,
   parameter int CNT_W     = 8
) (
   input logic              clk,
   input logic              reset,
   force_coalescer_if.slave bus
);
   localparam int DW = NUM_COMP * COMP_W;

   typedef enum logic {EMPTY = 1'b0, ACCUM = 1'b1} lane_state_t;

   lane_state_t          state    [NUM_LANES];
   logic [ID_W-1:0]      acc_id   [NUM_LANES];
   logic [DW-1:0]        acc_data [NUM_LANES];
   logic [CNT_W-1:0]     acc_cnt  [NUM_LANES];

   logic [NUM_LANES-1:0]      out_valid_q;
   logic [NUM_LANES*ID_W-1:0] out_id_q;
   logic [NUM_LANES*DW-1:0]   out_data_q;
   logic [NUM_LANES*CNT_W-1:0] out_cnt_q;
   logic [NUM_LANES-1:0]      overflow_q;
   logic                      flush_ack_q;
   logic                      ack_done;

   logic [NUM_LANES-1:0] slot_free;
   logic [NUM_LANES-1:0] accept;
   logic [NUM_LANES-1:0] drain;
   logic [NUM_LANES-1:0] same_id;
   logic [NUM_LANES-1:0] emit;
   logic [NUM_LANES-1:0] next_empty;
   logic [NUM_LANES-1:0] add_ovf;
   logic [DW-1:0]        sum_data [NUM_LANES];
   logic                 in_ready_c;

   // Two's-complement add returning {overflow, result}. Overflow means both
   // operands share a sign that the raw sum does not.
   function automatic logic [COMP_W:0] add_comp(input logic [COMP_W-1:0] a,
                                                input logic [COMP_W-1:0] b);
      logic [COMP_W-1:0] s;
      logic              v;
      s = a + b;
      v = (a[COMP_W-1] == b[COMP_W-1]) && (s[COMP_W-1] != a[COMP_W-1]);
`ifdef FORCE_COALESCER_SAT_EN
      if (v) begin
         s = a[COMP_W-1] ? {1'b1, {(COMP_W-1){1'b0}}} : {1'b0, {(COMP_W-1){1'b1}}};
      end
`else
      s = s;
`endif
      return {v, s};
   endfunction

   always_comb begin
      logic [COMP_W:0] r;
      r          = '0;
      slot_free  = '0;
      accept     = '0;
      drain      = '0;
      same_id    = '0;
      emit       = '0;
      next_empty = '0;
      add_ovf    = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         sum_data[l] = '0;
      end
      for (int l = 0; l < NUM_LANES; l++) begin
         // The output register can take a new record if it is empty or is
         // being consumed on this very edge.
         slot_free[l] = !out_valid_q[l] || bus.out_ready[l];
      end
      in_ready_c = !bus.flush && (&slot_free);
      for (int l = 0; l < NUM_LANES; l++) begin
         accept[l]  = bus.in_valid[l] && in_ready_c;
         drain[l]   = bus.flush && (state[l] == ACCUM) && slot_free[l];
         same_id[l] = (bus.in_id[l*ID_W +: ID_W] == acc_id[l]);
         emit[l]    = drain[l] || (accept[l] && (state[l] == ACCUM) && !same_id[l]);
         next_empty[l] = drain[l] || ((state[l] == EMPTY) && !accept[l]);
         for (int c = 0; c < NUM_COMP; c++) begin
            r = add_comp(acc_data[l][c*COMP_W +: COMP_W],
                         bus.in_data[(l*NUM_COMP + c)*COMP_W +: COMP_W]);
            sum_data[l][c*COMP_W +: COMP_W] = r[COMP_W-1:0];
            add_ovf[l] = add_ovf[l] | r[COMP_W];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= '0;
         out_id_q    <= '0;
         out_data_q  <= '0;
         out_cnt_q   <= '0;
         overflow_q  <= '0;
         flush_ack_q <= 1'b0;
         ack_done    <= 1'b0;
         for (int l = 0; l < NUM_LANES; l++) begin
            state[l]    <= EMPTY;
            acc_id[l]   <= '0;
            acc_data[l] <= '0;
            acc_cnt[l]  <= '0;
         end
      end else begin
         // The ack fires once per flush request: ack_done blocks repeats until
         // flush has been low for at least one edge.
         flush_ack_q <= bus.flush && (&next_empty) && !ack_done;
         if (!bus.flush) begin
            ack_done <= 1'b0;
         end else if (&next_empty) begin
            ack_done <= 1'b1;
         end

         for (int l = 0; l < NUM_LANES; l++) begin
            if (emit[l]) begin
               out_valid_q[l]                <= 1'b1;
               out_id_q[l*ID_W +: ID_W]      <= acc_id[l];
               out_data_q[l*DW +: DW]        <= acc_data[l];
               out_cnt_q[l*CNT_W +: CNT_W]   <= acc_cnt[l];
            end else if (bus.out_ready[l]) begin
               out_valid_q[l] <= 1'b0;
            end

            case (state[l])
               EMPTY: begin
                  if (accept[l]) begin
                     state[l]    <= ACCUM;
                     acc_id[l]   <= bus.in_id[l*ID_W +: ID_W];
                     acc_data[l] <= bus.in_data[l*DW +: DW];
                     acc_cnt[l]  <= CNT_W'(1);
                  end
               end
               ACCUM: begin
                  if (drain[l]) begin
                     state[l] <= EMPTY;
                  end else if (accept[l]) begin
                     if (same_id[l]) begin
                        acc_data[l] <= sum_data[l];
                        if (acc_cnt[l] != {CNT_W{1'b1}}) begin
                           acc_cnt[l] <= acc_cnt[l] + CNT_W'(1);
                        end
                        if (add_ovf[l]) begin
                           overflow_q[l] <= 1'b1;
                        end
                     end else begin
                        acc_id[l]   <= bus.in_id[l*ID_W +: ID_W];
                        acc_data[l] <= bus.in_data[l*DW +: DW];
                        acc_cnt[l]  <= CNT_W'(1);
                     end
                  end
               end
               default: state[l] <= EMPTY;
            endcase
         end
      end
   end

   always_comb begin
      bus.lane_state = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         bus.lane_state[l] = (state[l] == ACCUM);
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.flush_ack = flush_ack_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_id    = out_id_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_cnt   = out_cnt_q;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_force_coalescer.sv
// -----------------------------------------------------------------------------
// tb_force_coalescer
//
// Directed and randomized stimulus for force_coalescer (default parameters).
// A transaction-level model predicts every emitted record into a per-lane
// queue; a monitor pops and compares whenever a record is consumed.
// Follows FORCE_COALESCER_SAT_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_force_coalescer;
   localparam int ID_W = 16;
   localparam int DW   = 96;
   localparam int W    = ID_W + DW + 8;

   // clock / reset
   logic clk;
   logic reset;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   force_coalescer_if bus ();

   force_coalescer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic ready_mode = 1'b0;

   // model state
   logic [W-1:0]    exp_q0[$];
   logic [W-1:0]    exp_q1[$];
   logic            m_valid [2];
   logic [ID_W-1:0] m_id    [2];
   logic [DW-1:0]   m_d     [2];
   int              m_cnt   [2];
   logic [1:0]      m_ovf;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      exp_q0.delete();
      exp_q1.delete();
      for (int l = 0; l < 2; l++) begin
         m_valid[l] = 1'b0;
         m_id[l]    = '0;
         m_d[l]     = '0;
         m_cnt[l]   = 0;
      end
      m_ovf = '0;
   endtask

   task automatic model_push(input int l);
      logic [W-1:0] rec;
      rec = {m_id[l], m_d[l], 8'(m_cnt[l])};
      if (l == 0) exp_q0.push_back(rec);
      else        exp_q1.push_back(rec);
   endtask

   task automatic model_accept(input int l, input logic [ID_W-1:0] id, input logic [DW-1:0] d);
      longint s;
      logic [31:0] a, b, r;
      if (m_valid[l] && m_id[l] == id) begin
         for (int c = 0; c < 3; c++) begin
            a = m_d[l][c*32 +: 32];
            b = d[c*32 +: 32];
            s = longint'($signed(a)) + longint'($signed(b));
            r = 32'(s);
            if (s > 64'sd2147483647 || s < -64'sd2147483648) begin
               m_ovf[l] = 1'b1;
`ifdef FORCE_COALESCER_SAT_EN
               r = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
            end
            m_d[l][c*32 +: 32] = r;
         end
         m_cnt[l] = (m_cnt[l] >= 255) ? 255 : m_cnt[l] + 1;
      end else begin
         if (m_valid[l]) model_push(l);
         m_valid[l] = 1'b1;
         m_id[l]    = id;
         m_d[l]     = d;
         m_cnt[l]   = 1;
      end
   endtask

   task automatic model_flush();
      for (int l = 0; l < 2; l++) begin
         if (m_valid[l]) model_push(l);
         m_valid[l] = 1'b0;
      end
   endtask

   function automatic logic [DW-1:0] vec(input int x, input int y, input int z);
      return {32'(z), 32'(y), 32'(x)};
   endfunction

   // driver tasks
   task automatic set_inputs(input logic [1:0] v, input logic [ID_W-1:0] id0, input logic [ID_W-1:0] id1,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      bus.in_valid = v;
      bus.in_id    = {id1, id0};
      bus.in_data  = {d1, d0};
   endtask

   task automatic wait_accept();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.in_ready && n < 200);
      if (!bus.in_ready) begin
         chk("accept_timeout", 128'(0), 128'(1));
      end else begin
         for (int l = 0; l < 2; l++) begin
            if (bus.in_valid[l]) model_accept(l, bus.in_id[l*ID_W +: ID_W], bus.in_data[l*DW +: DW]);
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = '0;
   endtask

   task automatic drive(input logic [1:0] v, input logic [ID_W-1:0] id0, input logic [ID_W-1:0] id1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      set_inputs(v, id0, id1, d0, d1);
      wait_accept();
   endtask

   // exp_lat < 0 skips the latency comparison
   task automatic do_flush(input int exp_lat);
      int n;
      model_flush();
      bus.flush = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.flush_ack && n < 200);
      if (!bus.flush_ack) begin
         chk("flush_ack_timeout", 128'(0), 128'(1));
      end else if (exp_lat >= 0) begin
         chk("flush_ack_latency", 128'(n - 1), 128'(exp_lat));
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("flush_ack_single_pulse", 128'(bus.flush_ack), 128'(0));
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("queues_drained", 128'(exp_q0.size() + exp_q1.size()), 128'(0));
   endtask

   // random back-pressure
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode) bus.out_ready = 2'($urandom_range(0, 3));
      end
   end

   // scoreboard monitor
   logic [W-1:0] hold_rec [2];
   logic         hold_v   [2];
   initial begin
      hold_v[0] = 1'b0;
      hold_v[1] = 1'b0;
      forever begin
         @(negedge clk);
         for (int l = 0; l < 2; l++) begin
            logic [W-1:0] cur, exp;
            cur = {bus.out_id[l*ID_W +: ID_W], bus.out_data[l*DW +: DW], bus.out_cnt[l*8 +: 8]};
            if (reset || !bus.out_valid[l]) begin
               hold_v[l] = 1'b0;
            end else begin
               if (hold_v[l]) chk($sformatf("lane%0d_stable", l), 128'(cur), 128'(hold_rec[l]));
               if (bus.out_ready[l]) begin
                  hold_v[l] = 1'b0;
                  if ((l == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                     chk($sformatf("lane%0d_unexpected_output", l), 128'(cur), 128'(0));
                  end else begin
                     exp = (l == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                     chk($sformatf("lane%0d_record", l), 128'(cur), 128'(exp));
                  end
               end else begin
                  hold_v[l]   = 1'b1;
                  hold_rec[l] = cur;
               end
            end
         end
      end
   end

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // main sequence
   initial begin
      model_clear();
      reset         = 1'b1;
      bus.in_valid  = '0;
      bus.in_id     = '0;
      bus.in_data   = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", 128'(bus.out_valid), 128'(0));
      chk("reset_flush_ack", 128'(bus.flush_ack), 128'(0));
      chk("reset_overflow", 128'(bus.overflow), 128'(0));
      chk("reset_in_ready", 128'(bus.in_ready), 128'(1));
      chk("reset_out_id", 128'(bus.out_id), 128'(0));
      chk("reset_out_data", 128'(bus.out_data), 128'(0));
      chk("reset_out_cnt", 128'(bus.out_cnt), 128'(0));
      @(posedge clk);
      #1;

      // merge three contributions, displaced by a new id
      drive(2'b01, 16'd5, 16'd0, vec(1, 2, 3), '0);
      drive(2'b01, 16'd5, 16'd0, vec(10, 20, 30), '0);
      drive(2'b01, 16'd5, 16'd0, vec(-1, -2, -3), '0);
      drive(2'b01, 16'd7, 16'd0, vec(4, 4, 4), '0);
      @(negedge clk);
      chk("lane0_holds_id7", 128'(bus.lane_state), 128'(2'b01));
      @(posedge clk);
      #1;
      do_flush(1);
      wait_drain();

      // back-pressure on lane 1 stalls every lane
      bus.out_ready = 2'b01;
      drive(2'b10, 16'd0, 16'd9, '0, vec(1, 1, 1));
      drive(2'b10, 16'd0, 16'd10, '0, vec(2, 2, 2));
      set_inputs(2'b11, 16'd20, 16'd11, vec(5, 6, 7), vec(3, 3, 3));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("backpressure_in_ready", 128'(bus.in_ready), 128'(0));
         chk("backpressure_out_valid1", 128'(bus.out_valid[1]), 128'(1));
      end
      @(posedge clk);
      #1;
      bus.out_ready = 2'b11;
      wait_accept();
      do_flush(1);
      wait_drain();

      // overflow on lane 0
      drive(2'b01, 16'd3, 16'd0, {32'd0, 32'd0, 32'h7FFF_FFFF}, '0);
      drive(2'b01, 16'd3, 16'd0, {32'd0, 32'd0, 32'h7FFF_FFFF}, '0);
      @(negedge clk);
      chk("overflow_lane0", 128'(bus.overflow), 128'(2'b01));
      @(posedge clk);
      #1;
      do_flush(1);
      wait_drain();

      // counter saturation
      for (int i = 0; i < 300; i++) begin
         drive(2'b10, 16'd0, 16'd42, '0, vec(int'($urandom_range(0, 7)) - 3, 1, -1));
      end
      do_flush(1);
      wait_drain();

      // randomized traffic with random back-pressure and occasional flushes
      ready_mode = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 29) == 0) begin
            do_flush(-1);
         end else begin
            logic [DW-1:0] d0, d1;
            d0 = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom, $urandom}
                                             : vec(int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100, 5);
            d1 = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom, $urandom}
                                             : vec(int'($urandom_range(0, 200)) - 100, 7, int'($urandom_range(0, 200)) - 100);
            drive(2'($urandom_range(1, 3)), 16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)), d0, d1);
         end
      end
      @(posedge clk);
      #2;
      ready_mode = 1'b0;
      bus.out_ready = 2'b11;
      do_flush(-1);
      wait_drain();
      @(negedge clk);
      chk("overflow_model", 128'(bus.overflow), 128'(m_ovf));
      @(posedge clk);
      #1;

      // reset with both lanes accumulating and outputs pending
      bus.out_ready = 2'b00;
      drive(2'b11, 16'd1, 16'd1, vec(1, 1, 1), vec(2, 2, 2));
      drive(2'b11, 16'd2, 16'd2, vec(3, 3, 3), vec(4, 4, 4));
      @(negedge clk);
      chk("pending_before_reset", 128'(bus.out_valid), 128'(2'b11));
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_clear();
      @(negedge clk);
      chk("midreset_out_valid", 128'(bus.out_valid), 128'(0));
      chk("midreset_flush_ack", 128'(bus.flush_ack), 128'(0));
      chk("midreset_lane_state", 128'(bus.lane_state), 128'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.out_ready = 2'b11;
      @(posedge clk);
      #1;
      do_flush(1);
      repeat (3) @(negedge clk);
      chk("post_reset_no_output", 128'(exp_q0.size() + exp_q1.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
